// File: rtl/bec_ladder_sequencer.sv
// BEC ladder sequencer: captures six operands, walks the key one bit per ladder step through
// an external step unit, and writes step results back into the operand bank.
module bec_ladder_sequencer #(
   parameter int unsigned M            = 163,
   parameter int unsigned KEY_BITS     = 163,
   parameter int unsigned STEP_TIMEOUT = 4095
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_ni,
   input  logic         load_data,
   input  logic         trig_load,
   input  logic [2:0]   load_status,
   input  logic [M-1:0] op_in,
   input  logic         master_ena_proc,
   input  logic         ki,
   output logic         next_key,
   output logic         slv_done,
   output logic [3:0]   bec_status,
   output logic [M-1:0] rd_data,
   output logic         step_start,
   output logic         step_swap,
   input  logic         step_done,
   output logic [M-1:0] op_w1,
   output logic [M-1:0] op_z1,
   output logic [M-1:0] op_w2,
   output logic [M-1:0] op_z2,
   output logic [M-1:0] op_inv_w0,
   output logic [M-1:0] op_d,
   input  logic [M-1:0] res_w1,
   input  logic [M-1:0] res_z1,
   input  logic [M-1:0] res_w2,
   input  logic [M-1:0] res_z2
);

   localparam int unsigned CntW = $clog2(KEY_BITS + 1);
   localparam int unsigned TmoW = $clog2(STEP_TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle, StReady, StIssue, StWait, StSettle, StDone, StErr
   } state_e;

   state_e            state_q, state_d;
   logic [M-1:0]      bank_q [6];
   logic [5:0]        mask_q, mask_d;
   logic              trig_q, load_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic              next_key_q, next_key_d;
   logic              step_start_q, step_start_d;
   logic              step_swap_q, step_swap_d;
   logic              slv_done_q, slv_done_d;
   logic [M-1:0]      rd_data_q, rd_word;
   logic [3:0]        status_q, status_d;
   logic [3:0]        err_q, err_d;
   logic              abort_q, abort_d;
   logic              capture, writeback, load_rise, idx_ok, do_abort;

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      abort_d      = abort_q;
      err_d        = err_q;
      next_key_d   = 1'b0;
      step_start_d = 1'b0;
      step_swap_d  = step_swap_q;
      capture      = 1'b0;
      writeback    = 1'b0;
      do_abort     = 1'b0;
      load_rise    = trig_load & ~trig_q & load_data;
      idx_ok       = (load_status < 3'd6);

      if ((state_q == StIdle || state_q == StReady) && load_rise && idx_ok) begin
         capture = 1'b1;
         mask_d  = mask_q | (6'b1 << load_status);
         abort_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (mask_q == 6'h3F) begin
               state_d = StReady;
            end else if (master_ena_proc) begin
               state_d = StErr;
               err_d   = 4'd10;
            end
         end
         StReady: begin
            if (master_ena_proc) begin
               state_d = StIssue;
               cnt_d   = CntW'(KEY_BITS);
            end
         end
         StIssue: begin
            if (!master_ena_proc) begin
               do_abort = 1'b1;
            end else begin
               step_start_d = 1'b1;
               step_swap_d  = ki;
               tmo_d        = '0;
               state_d      = StWait;
            end
         end
         StWait: begin
            if (step_done) begin
               // Results are kept even when the run is being aborted this cycle.
               writeback = 1'b1;
               if (!master_ena_proc) begin
                  do_abort = 1'b1;
               end else begin
                  next_key_d = 1'b1;
                  cnt_d      = cnt_q - CntW'(1);
                  state_d    = StSettle;
               end
            end else if (!master_ena_proc) begin
               do_abort = 1'b1;
            end else if (tmo_q == TmoW'(STEP_TIMEOUT)) begin
               state_d = StErr;
               err_d   = 4'd9;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
         end
         StSettle: begin
            if (!master_ena_proc) begin
               do_abort = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = StDone;
            end else begin
               state_d = StIssue;
            end
         end
         StDone: begin
            if (load_data) begin
               state_d = StIdle;
               mask_d  = '0;
            end
         end
         StErr: begin
            if (load_data && !load_q) begin
               state_d = StIdle;
               mask_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_abort) begin
         state_d = StIdle;
         mask_d  = '0;
         abort_d = 1'b1;
      end

      slv_done_d = (state_d == StDone);

      unique case (state_d)
         StIdle: begin
            if (abort_d)                status_d = 4'd8;
            else if (mask_d == '0)      status_d = 4'd0;
            else if (mask_d == 6'h3F)   status_d = 4'd2;
            else                        status_d = 4'd1;
         end
         StReady:                       status_d = 4'd2;
         StIssue, StWait, StSettle:     status_d = 4'd3;
         StDone:                        status_d = 4'd4;
         StErr:                         status_d = err_d;
         default:                       status_d = 4'd0;
      endcase
   end

   always_comb begin
      rd_word = '0;
      case (load_status)
         3'd0:    rd_word = bank_q[0];
         3'd1:    rd_word = bank_q[1];
         3'd2:    rd_word = bank_q[2];
         3'd3:    rd_word = bank_q[3];
         3'd4:    rd_word = bank_q[4];
         3'd5:    rd_word = bank_q[5];
         default: rd_word = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state_q      <= StIdle;
         for (int i = 0; i < 6; i++) bank_q[i] <= '0;
         mask_q       <= '0;
         trig_q       <= 1'b0;
         load_q       <= 1'b0;
         cnt_q        <= CntW'(KEY_BITS);
         tmo_q        <= '0;
         next_key_q   <= 1'b0;
         step_start_q <= 1'b0;
         step_swap_q  <= 1'b0;
         slv_done_q   <= 1'b0;
         rd_data_q    <= '0;
         status_q     <= '0;
         err_q        <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         for (int i = 0; i < 6; i++) begin
            if (capture && load_status == 3'(i)) bank_q[i] <= op_in;
         end
         if (writeback) begin
            bank_q[0] <= res_w1;
            bank_q[1] <= res_z1;
            bank_q[2] <= res_w2;
            bank_q[3] <= res_z2;
         end
         mask_q       <= mask_d;
         trig_q       <= trig_load;
         load_q       <= load_data;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         next_key_q   <= next_key_d;
         step_start_q <= step_start_d;
         step_swap_q  <= step_swap_d;
         slv_done_q   <= slv_done_d;
         rd_data_q    <= rd_word;
         status_q     <= status_d;
         err_q        <= err_d;
         abort_q      <= abort_d;
      end
   end

   assign next_key   = next_key_q;
   assign slv_done   = slv_done_q;
   assign bec_status = status_q;
   assign rd_data    = rd_data_q;
   assign step_start = step_start_q;
   assign step_swap  = step_swap_q;
   assign op_w1      = bank_q[0];
   assign op_z1      = bank_q[1];
   assign op_w2      = bank_q[2];
   assign op_z2      = bank_q[3];
   assign op_inv_w0  = bank_q[4];
   assign op_d       = bank_q[5];

endmodule

// File: tb/tb_bec_ladder_sequencer.sv
// Self-checking bench for bec_ladder_sequencer: a controller/step-unit model drives runs and a
// reference operand bank predicts every writeback.
module tb_bec_ladder_sequencer;
   localparam int M = 163;
   localparam int KB = 4;

   logic         wb_clk_i = 1'b0;
   logic         wb_rst_ni = 1'b0;
   logic         load_data = 1'b0, trig_load = 1'b0;
   logic [2:0]   load_status = '0;
   logic [M-1:0] op_in = '0;
   logic         master_ena_proc = 1'b0, ki = 1'b0;
   logic         next_key, slv_done, step_start, step_swap;
   logic         step_done = 1'b0;
   logic [3:0]   bec_status;
   logic [M-1:0] rd_data;
   logic [M-1:0] op_w1, op_z1, op_w2, op_z2, op_inv_w0, op_d;
   logic [M-1:0] res_w1 = '0, res_z1 = '0, res_w2 = '0, res_z2 = '0;
   logic [M-1:0] ops [6];
   logic [M-1:0] exp_bank [6];

   int errors = 0, checks = 0;
   int nk_count = 0, ss_count = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   bec_ladder_sequencer #(.M(M), .KEY_BITS(KB), .STEP_TIMEOUT(15)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .load_data(load_data), .trig_load(trig_load),
      .load_status(load_status), .op_in(op_in), .master_ena_proc(master_ena_proc), .ki(ki),
      .next_key(next_key), .slv_done(slv_done), .bec_status(bec_status), .rd_data(rd_data),
      .step_start(step_start), .step_swap(step_swap), .step_done(step_done),
      .op_w1(op_w1), .op_z1(op_z1), .op_w2(op_w2), .op_z2(op_z2), .op_inv_w0(op_inv_w0),
      .op_d(op_d), .res_w1(res_w1), .res_z1(res_z1), .res_w2(res_w2), .res_z2(res_z2)
   );

   assign ops[0] = op_w1;
   assign ops[1] = op_z1;
   assign ops[2] = op_w2;
   assign ops[3] = op_z2;
   assign ops[4] = op_inv_w0;
   assign ops[5] = op_d;

   task automatic tick();
      @(negedge wb_clk_i);
      if (next_key === 1'b1) nk_count++;
      if (step_start === 1'b1) ss_count++;
   endtask

   function automatic logic [M-1:0] rand_word();
      logic [191:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return w[M-1:0];
   endfunction

   task automatic load_word(input logic [2:0] idx, input logic [M-1:0] val);
      load_data = 1'b1; trig_load = 1'b1; load_status = idx; op_in = val;
      tick();
      trig_load = 1'b0; load_data = 1'b0;
      tick();
   endtask

   task automatic load_all_random();
      logic [M-1:0] v;
      for (int i = 0; i < 6; i++) begin
         v = rand_word();
         exp_bank[i] = v;
         load_word(3'(i), v);
      end
   endtask

   task automatic go_idle();
      load_data = 1'b1;
      tick();
      load_data = 1'b0;
      tick();
      checks++;
      if (bec_status !== 4'd0) begin
         errors++; $display("FAIL go_idle_status: got %0d expected 0", bec_status);
      end
   endtask

   // One ladder run; abort_at>0 drops the run enable while waiting on that step.
   task automatic do_run(input logic [KB-1:0] key, input int lat, input int abort_at);
      int waited;
      logic [M-1:0] r [4];
      logic sw;
      nk_count = 0; ss_count = 0;
      ki = key[0];
      master_ena_proc = 1'b1;
      for (int s = 1; s <= KB; s++) begin
         waited = 0;
         while (step_start !== 1'b1 && waited < 50) begin tick(); waited++; end
         checks++;
         if (waited >= 50) begin
            errors++; $display("FAIL start_wait: step %0d got no step_start expected one", s);
            master_ena_proc = 1'b0;
            return;
         end
         sw = key[s-1];
         checks++;
         if (step_swap !== sw) begin
            errors++; $display("FAIL step_swap: step %0d got %b expected %b", s, step_swap, sw);
         end
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (ops[i] !== exp_bank[i]) begin
               errors++;
               $display("FAIL op_at_start: step %0d word %0d got %0h expected %0h",
                        s, i, ops[i], exp_bank[i]);
            end
         end
         if (s == abort_at) begin
            master_ena_proc = 1'b0;
            tick();
            return;
         end
         for (int c = 0; c < lat; c++) tick();
         r[0] = M'(s);
         r[1] = exp_bank[1] + exp_bank[2];
         r[2] = sw ? exp_bank[3] : (exp_bank[2] ^ exp_bank[5]);
         r[3] = exp_bank[3] + exp_bank[4] + M'(sw);
         res_w1 = r[0]; res_z1 = r[1]; res_w2 = r[2]; res_z2 = r[3];
         step_done = 1'b1;
         tick();
         step_done = 1'b0;
         for (int i = 0; i < 4; i++) exp_bank[i] = r[i];
         checks++;
         if (next_key !== 1'b1 || slv_done !== 1'b0) begin
            errors++;
            $display("FAIL settle: step %0d got next_key=%b slv_done=%b expected 1,0",
                     s, next_key, slv_done);
         end
         if (s < KB) ki = key[s];
      end
      tick();
      master_ena_proc = 1'b0;
      checks++;
      if (slv_done !== 1'b1 || bec_status !== 4'd4) begin
         errors++;
         $display("FAIL done: got slv_done=%b status=%0d expected 1,4", slv_done, bec_status);
      end
      checks++;
      if (nk_count != KB || ss_count != KB) begin
         errors++;
         $display("FAIL pulse_count: got next_key=%0d step_start=%0d expected %0d each",
                  nk_count, ss_count, KB);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ops[i] !== exp_bank[i]) begin
            errors++;
            $display("FAIL op_final: word %0d got %0h expected %0h", i, ops[i], exp_bank[i]);
         end
      end
   endtask

   task automatic test_reset();
      wb_rst_ni = 1'b0;
      tick(); tick();
      wb_rst_ni = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) exp_bank[i] = '0;
      checks++;
      if ({next_key, slv_done, step_start, step_swap, bec_status} !== 8'h00 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nk=%b done=%b start=%b swap=%b status=%0d rd=%0h",
                  next_key, slv_done, step_start, step_swap, bec_status, rd_data);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ops[i] !== '0) begin
            errors++; $display("FAIL reset_bank: word %0d got %0h expected 0", i, ops[i]);
         end
      end
   endtask

   task automatic test_load();
      for (int i = 0; i < 6; i++) begin
         exp_bank[i] = M'(i + 1);
         load_word(3'(i), M'(i + 1));
         if (i == 0) begin
            checks++;
            if (bec_status !== 4'd1) begin
               errors++; $display("FAIL partial_status: got %0d expected 1", bec_status);
            end
         end
      end
      load_word(3'd7, M'(32'hDEAD));
      tick();
      checks++;
      if (bec_status !== 4'd2) begin
         errors++; $display("FAIL ready_status: got %0d expected 2", bec_status);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ops[i] !== M'(i + 1)) begin
            errors++; $display("FAIL load_bank: word %0d got %0h expected %0h", i, ops[i], i + 1);
         end
      end
   endtask

   task automatic test_run();
      do_run(4'b1011, 3, 0);
      checks++;
      if (op_w1 !== M'(4)) begin
         errors++; $display("FAIL final_w1: got %0h expected 4", op_w1);
      end
   endtask

   task automatic test_readback();
      logic [M-1:0] want;
      for (int i = 0; i < 8; i++) begin
         load_status = 3'(i);
         tick();
         want = (i < 6) ? exp_bank[i] : '0;
         checks++;
         if (rd_data !== want) begin
            errors++; $display("FAIL readback: index %0d got %0h expected %0h", i, rd_data, want);
         end
      end
   endtask

   task automatic test_abort();
      go_idle();
      load_all_random();
      do_run(4'($urandom), 2, 2);
      for (int c = 0; c < 20; c++) tick();
      checks++;
      if (bec_status !== 4'd8 || slv_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_status: got status=%0d done=%b expected 8,0", bec_status, slv_done);
      end
      checks++;
      if (ss_count != 2 || nk_count != 1) begin
         errors++;
         $display("FAIL abort_pulses: got start=%0d next_key=%0d expected 2,1", ss_count, nk_count);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ops[i] !== exp_bank[i]) begin
            errors++;
            $display("FAIL abort_bank: word %0d got %0h expected %0h", i, ops[i], exp_bank[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int waited = 0;
      load_all_random();
      nk_count = 0; ss_count = 0;
      master_ena_proc = 1'b1;
      while (step_start !== 1'b1 && waited < 50) begin tick(); waited++; end
      checks++;
      if (waited >= 50) begin
         errors++; $display("FAIL timeout_start: got no step_start expected one");
      end
      for (int c = 0; c < 15; c++) tick();
      checks++;
      if (bec_status !== 4'd3) begin
         errors++; $display("FAIL timeout_early: got %0d expected 3", bec_status);
      end
      tick();
      checks++;
      if (bec_status !== 4'd9) begin
         errors++; $display("FAIL timeout_status: got %0d expected 9", bec_status);
      end
      master_ena_proc = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      checks++;
      if (nk_count != 0 || bec_status !== 4'd9) begin
         errors++;
         $display("FAIL timeout_hold: got next_key=%0d status=%0d expected 0,9",
                  nk_count, bec_status);
      end
      go_idle();
   endtask

   task automatic test_reset_midrun();
      int waited = 0;
      load_all_random();
      master_ena_proc = 1'b1;
      ki = 1'b1;
      while (step_start !== 1'b1 && waited < 50) begin tick(); waited++; end
      tick();
      wb_rst_ni = 1'b0; master_ena_proc = 1'b0;
      tick();
      wb_rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) exp_bank[i] = '0;
      checks++;
      if ({next_key, slv_done, step_start, step_swap, bec_status} !== 8'h00 || rd_data !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got nk=%b done=%b start=%b swap=%b status=%0d rd=%0h",
                  next_key, slv_done, step_start, step_swap, bec_status, rd_data);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ops[i] !== '0) begin
            errors++; $display("FAIL midrun_bank: word %0d got %0h expected 0", i, ops[i]);
         end
      end
      load_all_random();
      do_run(4'($urandom), $urandom_range(1, 6), 0);
   endtask

   task automatic test_random_runs();
      for (int n = 0; n < 3; n++) begin
         go_idle();
         load_all_random();
         do_run(4'($urandom), $urandom_range(1, 6), 0);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_run();
      test_readback();
      test_abort();
      test_timeout();
      test_reset_midrun();
      test_random_runs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1);
   end

endmodule
